// File: rtl/stream_sink_monitor_if.sv
// AXI4-Stream style beat bundle between a traffic source and stream_sink_monitor.
// A beat transfers on a rising clk edge where tvalid and tready are both 1; tready may depend only on registered state.
interface stream_sink_monitor_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;

  modport master (
    output tvalid,
    output tdata,
    output tstrb,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tstrb,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/stream_sink_monitor.sv
// Stream sink with programmable backpressure and saturating beat/packet/byte statistics.
// Define STREAM_SINK_CHECK_EN to build the incrementing-data checker that drives err_count.
module stream_sink_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 aresetn,
  stream_sink_monitor_if.slave s_axis,
  input  logic                 clear,
  input  logic                 throttle_en,
  input  logic [7:0]           throttle_on,
  input  logic [7:0]           throttle_off,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] byte_count,
  output logic                 in_packet,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [1:0]           fsm_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PCW    = $clog2(STRB_W + 1);
  localparam int SUMW   = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 32) begin : g_bad_data_width
    $error("stream_sink_monitor: DATA_WIDTH must be a multiple of 8 and at least 32");
  end

  typedef enum logic [1:0] {
    ST_RST = 2'd0,
    ST_ON  = 2'd1,
    ST_OFF = 2'd2
  } thr_state_t;

  thr_state_t state, state_n;
  logic [7:0] cyc, cyc_n;
  logic [8:0] cyc_inc;
  logic [7:0] on_len;
  logic       tready_q;
  logic       accept;

  assign on_len  = (throttle_on == 8'd0) ? 8'd1 : throttle_on;
  assign cyc_inc = {1'b0, cyc} + 9'd1;

  // cyc counts clocks spent in the current state; it restarts on every state change.
  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    case (state)
      ST_RST: begin
        state_n = ST_ON;
        cyc_n   = 8'd0;
      end
      ST_ON: begin
        if (!throttle_en || throttle_off == 8'd0) begin
          cyc_n = 8'd0;
        end else if (cyc_inc >= {1'b0, on_len}) begin
          state_n = ST_OFF;
          cyc_n   = 8'd0;
        end else begin
          cyc_n = cyc_inc[7:0];
        end
      end
      ST_OFF: begin
        if (!throttle_en || cyc_inc >= {1'b0, throttle_off}) begin
          state_n = ST_ON;
          cyc_n   = 8'd0;
        end else begin
          cyc_n = cyc_inc[7:0];
        end
      end
      default: begin
        state_n = ST_ON;
        cyc_n   = 8'd0;
      end
    endcase
  end

  // tready is a flop loaded from the next state so it matches the state register exactly.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_RST;
      cyc      <= 8'd0;
      tready_q <= 1'b0;
    end else begin
      state    <= state_n;
      cyc      <= cyc_n;
      tready_q <= (state_n == ST_ON);
    end
  end

  assign s_axis.tready = tready_q;
  assign fsm_state     = state;
  assign accept        = s_axis.tvalid & tready_q;

  function automatic logic [PCW-1:0] popcount(input logic [STRB_W-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < STRB_W; i++) begin
      n = n + PCW'(v[i]);
    end
    return n;
  endfunction

  logic [PCW-1:0]       strb_pop;
  logic [SUMW-1:0]      byte_sum;
  logic [CNT_WIDTH-1:0] byte_next;

  // The sum is one bit wider than either operand so overflow shows up as a value above CNT_MAX.
  assign strb_pop  = popcount(s_axis.tstrb);
  assign byte_sum  = SUMW'(byte_count) + SUMW'(strb_pop);
  assign byte_next = (byte_sum > SUMW'(CNT_MAX)) ? CNT_MAX : byte_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      beat_count <= '0;
      pkt_count  <= '0;
      byte_count <= '0;
      in_packet  <= 1'b0;
    end else if (clear) begin
      beat_count <= '0;
      pkt_count  <= '0;
      byte_count <= '0;
      in_packet  <= 1'b0;
    end else if (accept) begin
      if (beat_count != CNT_MAX) beat_count <= beat_count + CNT_ONE;
      if (s_axis.tlast && pkt_count != CNT_MAX) pkt_count <= pkt_count + CNT_ONE;
      byte_count <= byte_next;
      in_packet  <= ~s_axis.tlast;
    end
  end

  logic unused_tdata;
  assign unused_tdata = ^s_axis.tdata;

`ifdef STREAM_SINK_CHECK_EN
  logic [31:0] exp_data;

  // On a mismatch the checker resynchronises to the received value instead of flagging every later beat.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      exp_data  <= 32'd0;
      err_count <= '0;
    end else if (clear) begin
      exp_data  <= 32'd0;
      err_count <= '0;
    end else if (accept) begin
      if (s_axis.tdata[31:0] == exp_data) begin
        exp_data <= exp_data + 32'd1;
      end else begin
        exp_data <= s_axis.tdata[31:0] + 32'd1;
        if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
      end
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_stream_sink_monitor.sv
// Bench for stream_sink_monitor: a 32-bit-counter and a 4-bit-counter instance share one stimulus stream.
// Expectations come from a cycle-index throttle model and unbounded counters clipped to each width.
module tb_stream_sink_monitor;

  localparam int DW  = 64;
  localparam int CWB = 32;
  localparam int CWS = 4;

  logic clk;
  logic aresetn;
  logic clear;
  logic throttle_en;
  logic [7:0] throttle_on;
  logic [7:0] throttle_off;
  logic tvalid;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic tlast;

  logic [CWB-1:0] b_beat, b_pkt, b_byte, b_err;
  logic [CWS-1:0] s_beat, s_pkt, s_byte, s_err;
  logic b_inpkt, s_inpkt;
  logic [1:0] b_state, s_state;

  stream_sink_monitor_if #(.DATA_WIDTH(DW)) big_if ();
  stream_sink_monitor_if #(.DATA_WIDTH(DW)) small_if ();

  assign big_if.tvalid   = tvalid;
  assign big_if.tdata    = tdata;
  assign big_if.tstrb    = tstrb;
  assign big_if.tlast    = tlast;
  assign small_if.tvalid = tvalid;
  assign small_if.tdata  = tdata;
  assign small_if.tstrb  = tstrb;
  assign small_if.tlast  = tlast;

  stream_sink_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CWB)) dut (
    .clk(clk), .aresetn(aresetn), .s_axis(big_if), .clear(clear),
    .throttle_en(throttle_en), .throttle_on(throttle_on), .throttle_off(throttle_off),
    .beat_count(b_beat), .pkt_count(b_pkt), .byte_count(b_byte), .in_packet(b_inpkt),
    .err_count(b_err), .fsm_state(b_state)
  );

  stream_sink_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CWS)) dut_s (
    .clk(clk), .aresetn(aresetn), .s_axis(small_if), .clear(clear),
    .throttle_en(throttle_en), .throttle_on(throttle_on), .throttle_off(throttle_off),
    .beat_count(s_beat), .pkt_count(s_pkt), .byte_count(s_byte), .in_packet(s_inpkt),
    .err_count(s_err), .fsm_state(s_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state
  longint      m_beats, m_pkts, m_bytes, m_err;
  bit          m_inpkt;
  logic [31:0] m_exp;
  bit          m_rst;
  bit          m_thr;
  bit          m_drop;
  int          m_phase;
  int          m_on, m_off;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) <<< w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Ready pattern: zero in the cycle after reset release, then on'-high / off-low periods from phase 0.
  function automatic bit exp_ready();
    if (m_rst) return 1'b0;
    if (!m_thr) return 1'b1;
    return (m_phase % (m_on + m_off)) < m_on;
  endfunction

  task automatic model_zero();
    m_beats = 0; m_pkts = 0; m_bytes = 0; m_err = 0;
    m_inpkt = 1'b0; m_exp = 32'd0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".beat"},   b_beat,  sat(m_beats, CWB));
    check({tag, ".pkt"},    b_pkt,   sat(m_pkts, CWB));
    check({tag, ".byte"},   b_byte,  sat(m_bytes, CWB));
    check({tag, ".err"},    b_err,   sat(m_err, CWB));
    check({tag, ".inpkt"},  b_inpkt, m_inpkt);
    check({tag, ".sbeat"},  s_beat,  sat(m_beats, CWS));
    check({tag, ".spkt"},   s_pkt,   sat(m_pkts, CWS));
    check({tag, ".sbyte"},  s_byte,  sat(m_bytes, CWS));
    check({tag, ".serr"},   s_err,   sat(m_err, CWS));
    check({tag, ".sinpkt"}, s_inpkt, m_inpkt);
  endtask

  // Throttle is only (re)enabled while the sink is known to be in ON with its cycle count at zero.
  task automatic set_throttle(input bit en, input int on, input int off);
    throttle_en  = en;
    throttle_on  = 8'(on);
    throttle_off = 8'(off);
    if (en && off != 0) begin
      m_thr   = 1'b1;
      m_phase = 0;
      m_on    = (on == 0) ? 1 : on;
      m_off   = off;
    end else if (m_thr) begin
      m_drop = 1'b1;
    end
  endtask

  // Driver: present one cycle of inputs, check tready, advance the model, check counters after the edge.
  task automatic step(input bit v, input logic [63:0] d, input logic [7:0] s, input bit l, input bit c,
                      input string tag);
    bit er;
    tvalid = v; tdata = d; tstrb = s; tlast = l; clear = c;
    er = exp_ready();
    check({tag, ".tready"},  big_if.tready,   er);
    check({tag, ".stready"}, small_if.tready, er);
    if (c) begin
      model_zero();
    end else if (v && er) begin
      m_beats++;
      if (l) m_pkts++;
      m_bytes += $countones(s);
      m_inpkt = !l;
`ifdef STREAM_SINK_CHECK_EN
      if (d[31:0] == m_exp) begin
        m_exp = m_exp + 32'd1;
      end else begin
        m_err++;
        m_exp = d[31:0] + 32'd1;
      end
`endif
    end
    @(posedge clk);
    #1;
    if (m_rst) begin
      m_rst = 1'b0;
      m_phase = 0;
    end else begin
      m_phase++;
    end
    if (m_drop) begin
      m_thr = 1'b0;
      m_drop = 1'b0;
    end
    clear = 1'b0;
    check_counters(tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle; returns mid-cycle just after release.
  task automatic do_reset(input string tag);
    #3 aresetn = 1'b0;
    #1;
    check({tag, ".rst_tready"},  big_if.tready,   1'b0);
    check({tag, ".rst_stready"}, small_if.tready, 1'b0);
    model_zero();
    check_counters({tag, ".rst"});
    tvalid = 1'b0;
    @(posedge clk);
    #4 aresetn = 1'b1;
    m_rst = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    aresetn = 1'b0; clear = 1'b0;
    throttle_en = 1'b0; throttle_on = 8'd0; throttle_off = 8'd0;
    tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0;
    m_thr = 1'b0; m_drop = 1'b0; m_rst = 1'b0; m_phase = 0; m_on = 1; m_off = 0;
    model_zero();
    @(posedge clk); #1;

    // Unthrottled start: one not-ready cycle, then ten beats.
    do_reset("init");
    for (int i = 0; i < 11; i++) step(1'b1, {32'd0, m_exp}, 8'hFF, 1'b0, 1'b0, "free");
    check("free.beat10", b_beat, 64'd10);

    // Three 4-beat packets, last beat strobe 0x0F.
    step(1'b0, '0, 8'h00, 1'b0, 1'b1, "clr0");
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 4; b++) begin
        step(1'b1, {32'd0, m_exp}, (b == 3) ? 8'h0F : 8'hFF, (b == 3), 1'b0, "pkt");
      end
    end
    check("pkt.pkt3",    b_pkt,   64'd3);
    check("pkt.beat12",  b_beat,  64'd12);
    check("pkt.byte84",  b_byte,  64'd84);
    check("pkt.inpkt0",  b_inpkt, 64'd0);

    // on=3 off=2 throttle from reset, then drop throttle_en while in OFF.
    set_throttle(1'b1, 3, 2);
    do_reset("thr");
    for (int i = 0; i < 21; i++) step(1'b1, {32'd0, m_exp}, 8'h01, 1'b0, 1'b0, "thr");
    check("thr.beat12", b_beat, 64'd12);
    for (int i = 0; i < 6 && exp_ready(); i++) step(1'b1, {32'd0, m_exp}, 8'h01, 1'b0, 1'b0, "thr_seek");
    check("thr.in_off", big_if.tready, 64'd0);
    set_throttle(1'b0, 3, 2);
    step(1'b1, {32'd0, m_exp}, 8'h01, 1'b0, 1'b0, "thr_drop");
    check("thr.forced_on", big_if.tready, 64'd1);

    // Clear on an accept after 15 beats, then saturate the 4-bit instance.
    do_reset("sat");
    for (int i = 0; i < 16; i++) step(1'b1, {32'd0, m_exp}, 8'h03, 1'b0, 1'b0, "sat_fill");
    check("sat.s15", s_beat, 64'd15);
    step(1'b1, {32'd0, m_exp}, 8'h03, 1'b1, 1'b1, "sat_clr");
    check("sat.clr_b", b_beat, 64'd0);
    check("sat.clr_s", s_beat, 64'd0);
    for (int i = 0; i < 20; i++) step(1'b1, {32'd0, m_exp}, 8'h03, 1'b0, 1'b0, "sat_run");
    check("sat.s_hold15", s_beat, 64'd15);
    check("sat.b20",      b_beat, 64'd20);
    check("sat.midpkt",   b_inpkt, 64'd1);
    do_reset("midpkt");
    check("midpkt.inpkt", b_inpkt, 64'd0);
    check("midpkt.beat",  b_beat,  64'd0);
    step(1'b0, '0, 8'h00, 1'b0, 1'b0, "midpkt_rel");

`ifdef STREAM_SINK_CHECK_EN
    step(1'b0, '0, 8'h00, 1'b0, 1'b1, "chk_clr");
    step(1'b1, 64'd0, 8'hFF, 1'b0, 1'b0, "chk");
    step(1'b1, 64'd1, 8'hFF, 1'b0, 1'b0, "chk");
    step(1'b1, 64'd2, 8'hFF, 1'b0, 1'b0, "chk");
    step(1'b1, 64'd7, 8'hFF, 1'b0, 1'b0, "chk");
    step(1'b1, 64'd8, 8'hFF, 1'b0, 1'b0, "chk");
    check("chk.err1", b_err, 64'd1);
    step(1'b1, 64'd9, 8'hFF, 1'b1, 1'b0, "chk_next9");
    check("chk.err_still1", b_err, 64'd1);
`else
    check("nochk.err0", b_err, 64'd0);
`endif

    // Randomised traffic under a random throttle pattern, with clears, a throttle toggle and a reset.
    set_throttle(1'b1, $urandom_range(0, 4), $urandom_range(0, 3));
    do_reset("rnd");
    for (int i = 0; i < 300; i++) begin
      logic [63:0] d;
      d = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : {$urandom, m_exp};
      if (i == 150) set_throttle(1'b0, 0, 0);
      if (i == 200) set_throttle(1'b1, $urandom_range(0, 5), $urandom_range(1, 4));
      if (i == 250) do_reset("rnd_rst");
      step($urandom_range(0, 3) != 0, d, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 40) == 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
